mem_io_bridge: RTL and testbench

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

---
 rtl/mem_io_bridge_if.sv | 38 +++
 rtl/mem_io_bridge.sv | 155 +++++++++++++++
 tb/tb_mem_io_bridge.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: bundles the CPU request/response, memory and IO channel signals of the bridge
//   slave  : bridge view (drives req_ready, rdata, rsp_*, addr_out, m_*_en, m_wdata, io_cs, io_we, io_wdata)
//   master : environment view (CPU drives the request, memory drives m_rdata, IO devices drive io_rdata/io_ack)
interface mem_io_bridge_if #(
    parameter int NUM_IO = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  rd_en;
    logic                  wr_en;
    logic [31:0]           addr_in;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [31:0]           addr_out;
    logic                  m_read_en;
    logic                  m_write_en;
    logic [31:0]           m_wdata;
    logic [31:0]           m_rdata;
    logic [NUM_IO-1:0]     io_cs;
    logic                  io_we;
    logic [31:0]           io_wdata;
    logic [32*NUM_IO-1:0]  io_rdata;
    logic [NUM_IO-1:0]     io_ack;

    modport slave (
        input  req_valid, rd_en, wr_en, addr_in, wdata, m_rdata, io_rdata, io_ack,
        output req_ready, rdata, rsp_valid, rsp_err, addr_out, m_read_en, m_write_en,
               m_wdata, io_cs, io_we, io_wdata
    );

    modport master (
        output req_valid, rd_en, wr_en, addr_in, wdata, m_rdata, io_rdata, io_ack,
        input  req_ready, rdata, rsp_valid, rsp_err, addr_out, m_read_en, m_write_en,
               m_wdata, io_cs, io_we, io_wdata
    );
endinterface

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: routes CPU load/store requests to memory or to one of NUM_IO IO channels
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : request (req_valid/req_ready/rd_en/wr_en/addr_in/wdata), response (rdata/rsp_valid/rsp_err),
//                  memory port (addr_out/m_read_en/m_write_en/m_wdata/m_rdata),
//                  IO port (io_cs/io_we/io_wdata/io_rdata/io_ack)
//   Define MEMIO_TIMEOUT_EN to give up on an IO channel after TIMEOUT cycles without io_ack.
module mem_io_bridge #(
    parameter int          NUM_IO       = 4,
    parameter logic [31:0] IO_BASE      = 32'hFFFFFC00,
    parameter int          IO_SPAN_LOG2 = 4,
    parameter int          TIMEOUT      = 15
) (
    input logic            clock,
    input logic            reset,
    mem_io_bridge_if.slave bus
);
    localparam int CW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    typedef enum logic [2:0] {IDLE, MEM, MEMW, IO, RESP} state_t;

    state_t            state;
    logic              ready_q, rv_q, err_q, mre_q, mwe_q, we_q, rd_q;
    logic [NUM_IO-1:0] cs_q;
    logic [CW-1:0]     ch_q;
    logic [31:0]       addr_q, wdata_q, rdata_q;

    logic              is_io, in_range, ack_sel;
    logic [31:0]       chan;
    logic [NUM_IO-1:0] cs_dec;
    logic [31:0]       io_sel;

`ifdef MEMIO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    assign is_io    = bus.addr_in >= IO_BASE;
    assign chan     = (bus.addr_in - IO_BASE) >> IO_SPAN_LOG2;
    assign in_range = chan < 32'(NUM_IO);
    assign cs_dec   = NUM_IO'(1) << chan[CW-1:0];
    // only the latched channel's ack/data matter; others are don't-care
    assign ack_sel  = bus.io_ack[ch_q];
    assign io_sel   = bus.io_rdata[32*ch_q +: 32];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            mre_q   <= 1'b0;
            mwe_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            cs_q    <= '0;
            ch_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEMIO_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            rv_q  <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    // ready_q gates acceptance so nothing is taken in the first cycle after reset
                    if (bus.req_valid && ready_q && (bus.rd_en || bus.wr_en)) begin
                        ready_q <= 1'b0;
                        if (bus.rd_en && bus.wr_en) begin
                            state   <= RESP;
                            rv_q    <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            addr_q  <= bus.addr_in;
                            wdata_q <= bus.wdata;
                            rd_q    <= bus.rd_en;
                            if (!is_io) begin
                                state <= MEM;
                                mre_q <= bus.rd_en;
                                mwe_q <= bus.wr_en;
                            end else if (in_range) begin
                                state <= IO;
                                cs_q  <= cs_dec;
                                we_q  <= bus.wr_en;
                                ch_q  <= chan[CW-1:0];
`ifdef MEMIO_TIMEOUT_EN
                                tmo_cnt <= '0;
`endif
                            end else begin
                                state   <= RESP;
                                rv_q    <= 1'b1;
                                err_q   <= 1'b1;
                                rdata_q <= '0;
                            end
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                MEM: begin
                    state <= MEMW;
                    mre_q <= 1'b0;
                    mwe_q <= 1'b0;
                end
                MEMW: begin
                    state   <= RESP;
                    rv_q    <= 1'b1;
                    rdata_q <= rd_q ? bus.m_rdata : '0;
                end
                IO: begin
                    if (ack_sel) begin
                        state   <= RESP;
                        rv_q    <= 1'b1;
                        rdata_q <= rd_q ? io_sel : '0;
                        cs_q    <= '0;
                        we_q    <= 1'b0;
`ifdef MEMIO_TIMEOUT_EN
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state   <= RESP;
                        rv_q    <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        cs_q    <= '0;
                        we_q    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rv_q;
    assign bus.rsp_err    = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.addr_out   = addr_q;
    assign bus.m_read_en  = mre_q;
    assign bus.m_write_en = mwe_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.io_cs      = cs_q;
    assign bus.io_we      = we_q;
    assign bus.io_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: per-cycle model check of mem_io_bridge plus literal pins on key scenarios
module tb_mem_io_bridge;
    localparam int          NUM_IO  = 4;
    localparam logic [31:0] IO_BASE = 32'hFFFFFC00;
    localparam int          TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mem_io_bridge_if #(.NUM_IO(NUM_IO)) bus();

    mem_io_bridge #(
        .NUM_IO(NUM_IO), .IO_BASE(IO_BASE), .IO_SPAN_LOG2(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0, cycle = 0;
    logic chk_en = 1'b0, wd_chk = 1'b0;
    logic e_ready, e_mre, e_mwe, e_we, e_rv, e_err;
    logic [NUM_IO-1:0] e_cs;
    logic [31:0] e_rdata, e_addr = '0, e_wd = '0, mdl_rdata = '0;
    logic [31:0] io_mem [NUM_IO];

    int mre_n, mwe_n, cs_n, rsp_n = 0, rsp_cyc, acc_cyc;
    logic [NUM_IO-1:0] cs_seen;
    logic rsp_err_v;

    always @(negedge clock) begin
        cycle++;
        if (bus.m_read_en)  mre_n++;
        if (bus.m_write_en) mwe_n++;
        if (bus.io_cs != '0) begin cs_n++; cs_seen = cs_seen | bus.io_cs; end
        if (bus.rsp_valid) begin rsp_n++; rsp_cyc = cycle; rsp_err_v = bus.rsp_err; end
        if (chk_en) begin
            n_chk++;
            if ({bus.req_ready, bus.m_read_en, bus.m_write_en, bus.io_cs, bus.io_we, bus.rsp_valid,
                 bus.rsp_err, bus.rdata, bus.addr_out} ===
                {e_ready, e_mre, e_mwe, e_cs, e_we, e_rv, e_err, e_rdata, e_addr})
                n_pass++;
            else
                $display("FAIL outputs cyc=%0d got rdy=%b mre=%b mwe=%b cs=%b we=%b rv=%b err=%b rdata=%h addr=%h exp rdy=%b mre=%b mwe=%b cs=%b we=%b rv=%b err=%b rdata=%h addr=%h",
                         cycle, bus.req_ready, bus.m_read_en, bus.m_write_en, bus.io_cs, bus.io_we,
                         bus.rsp_valid, bus.rsp_err, bus.rdata, bus.addr_out,
                         e_ready, e_mre, e_mwe, e_cs, e_we, e_rv, e_err, e_rdata, e_addr);
            if (wd_chk) begin
                n_chk++;
                if (bus.m_wdata === e_wd && bus.io_wdata === e_wd) n_pass++;
                else $display("FAIL wdata cyc=%0d got m=%h io=%h exp %h", cycle, bus.m_wdata, bus.io_wdata, e_wd);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", name, act, exp);
    endtask

    task automatic busy();
        e_ready = 0; e_mre = 0; e_mwe = 0; e_cs = '0; e_we = 0; e_rv = 0; e_err = 0;
        e_rdata = mdl_rdata; wd_chk = 0;
    endtask

    task automatic idle_exp();
        busy();
        e_ready = 1;
    endtask

    task automatic resp(input logic err, input logic [31:0] rd);
        busy();
        mdl_rdata = rd;
        e_rv = 1; e_err = err; e_rdata = rd;
    endtask

    // model of one request, issued from an idle cycle; returns in the next idle cycle
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] mrd, input int ack_at);
        logic [31:0] ch;
        logic [NUM_IO-1:0] oh;
        int lim;
        mre_n = 0; mwe_n = 0; cs_n = 0; cs_seen = '0; rsp_err_v = 0;
        acc_cyc = cycle + 1;
        bus.req_valid = 1; bus.rd_en = rd; bus.wr_en = wr; bus.addr_in = addr; bus.wdata = wd;
        bus.io_ack = '1; bus.m_rdata = ~mrd;
        cyc();
        bus.req_valid = 0; bus.rd_en = 0; bus.wr_en = 0; bus.io_ack = '0;
        bus.addr_in = $urandom; bus.wdata = $urandom;
        if (!rd && !wr) begin idle_exp(); return; end
        if (rd && wr) begin resp(1, 0); cyc(); idle_exp(); return; end
        e_addr = addr; e_wd = wd;
        if (addr < IO_BASE) begin
            busy(); wd_chk = 1; e_mre = rd; e_mwe = wr;
            cyc();
            busy(); wd_chk = 1; bus.m_rdata = mrd;
            cyc();
            resp(0, rd ? mrd : 32'h0); wd_chk = 1; bus.m_rdata = ~mrd;
            cyc(); idle_exp();
            return;
        end
        ch = (addr - IO_BASE) >> 4;
        if (ch >= NUM_IO) begin resp(1, 0); cyc(); idle_exp(); return; end
        oh = NUM_IO'(1) << ch;
        lim = ack_at;
`ifdef MEMIO_TIMEOUT_EN
        if (ack_at == 0 || ack_at > TIMEOUT) lim = TIMEOUT;
`endif
        for (int k = 1; k <= lim; k++) begin
            busy(); wd_chk = 1; e_cs = oh; e_we = wr;
            bus.io_ack = (k == ack_at) ? oh : ~oh;
            cyc();
        end
        bus.io_ack = '0;
        resp(ack_at != lim, (ack_at == lim && rd) ? io_mem[ch] : 32'h0); wd_chk = 1;
        cyc(); idle_exp();
    endtask

    initial begin
        int rn;
        io_mem[0] = 32'h1111_1111; io_mem[1] = 32'h2222_2222;
        io_mem[2] = 32'h3333_3333; io_mem[3] = 32'h4444_4444;
        for (int k = 0; k < NUM_IO; k++) bus.io_rdata[32*k +: 32] = io_mem[k];
        bus.req_valid = 0; bus.rd_en = 0; bus.wr_en = 0; bus.addr_in = '0; bus.wdata = '0;
        bus.m_rdata = '0; bus.io_ack = '0;
        cyc();
        busy(); chk_en = 1;
        cyc();
        reset = 0;
        cyc(); idle_exp();
        pin("ready_after_reset", {31'b0, bus.req_ready}, 32'h1);

        txn(1, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);
        pin("mem_rd_rdata", bus.rdata, 32'hDEAD_BEEF);
        pin("mem_rd_latency", rsp_cyc - acc_cyc, 3);
        pin("mem_rd_strobe_cycles", mre_n, 1);
        pin("mem_rd_err", {31'b0, rsp_err_v}, 0);

        txn(0, 1, 32'h0000_0100, 32'h1234_5678, 32'h5555_5555, 0);
        pin("mem_wr_rdata", bus.rdata, 0);
        pin("mem_wr_strobe_cycles", mwe_n, 1);

        txn(0, 1, IO_BASE + 32'h20, 32'hA5, 32'h0, 3);
        pin("io_wr_cs", {28'b0, cs_seen}, 32'b0100);
        pin("io_wr_cs_cycles", cs_n, 3);
        pin("io_wr_err", {31'b0, rsp_err_v}, 0);

        txn(1, 0, IO_BASE + 32'h30, 32'h0, 32'h0, 1);
        pin("io_rd_ch3", bus.rdata, 32'h4444_4444);

        txn(1, 0, IO_BASE + 32'h40, 32'h0, 32'h0, 0);
        pin("io_oor_cs_cycles", cs_n, 0);
        pin("io_oor_err", {31'b0, rsp_err_v}, 1);
        pin("io_oor_latency", rsp_cyc - acc_cyc, 1);
        pin("io_oor_rdata", bus.rdata, 0);

        txn(0, 0, 32'h0000_0200, 32'h0, 32'h0, 0);
        rn = rsp_n;
        txn(1, 1, 32'h0000_0300, 32'h77, 32'h0, 0);
        pin("both_en_err", {31'b0, rsp_err_v}, 1);
        pin("both_en_strobes", mre_n + mwe_n + cs_n, 0);
        pin("both_en_one_rsp", rsp_n - rn, 1);

        txn(1, 0, IO_BASE + 32'h10, 32'h0, 32'h0, TIMEOUT);
        pin("io_ack_at_limit", bus.rdata, 32'h2222_2222);

        txn(1, 0, IO_BASE - 32'h4, 32'h0, 32'hCAFE_F00D, 0);
        pin("mem_below_base", bus.rdata, 32'hCAFE_F00D);

        txn(1, 0, IO_BASE + 32'h10, 32'h0, 32'h0, 20);
`ifdef MEMIO_TIMEOUT_EN
        pin("io_timeout_cs_cycles", cs_n, 15);
        pin("io_timeout_err", {31'b0, rsp_err_v}, 1);
`else
        pin("io_wait_cs_cycles", cs_n, 20);
        pin("io_wait_err", {31'b0, rsp_err_v}, 0);
`endif

        rn = rsp_n;
        bus.req_valid = 1; bus.rd_en = 1; bus.addr_in = IO_BASE; bus.wdata = 32'h0;
        cyc();
        bus.req_valid = 0; bus.rd_en = 0;
        e_addr = IO_BASE; e_wd = 32'h0;
        for (int k = 0; k < 3; k++) begin
            busy(); wd_chk = 1; e_cs = 4'b0001;
            if (k == 2) reset = 1;
            cyc();
        end
        mdl_rdata = 0; e_addr = 0; busy();
        reset = 0;
        cyc(); idle_exp();
        pin("reset_mid_io_ready", {31'b0, bus.req_ready}, 1);
        pin("reset_mid_io_no_rsp", rsp_n - rn, 0);

        txn(1, 0, IO_BASE + 32'h20, 32'h0, 32'h0, 2);
        pin("io_rd_after_reset", bus.rdata, 32'h3333_3333);
        cyc();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
